// File: rtl/cell_comm_rx_parser.sv
// Receive-side parser for one cell-comm Aurora ring direction.
// Frames 4-word BPM FA packets (header, X, Y, S), checks the link CRC result,
// emits one parsed record per good packet and keeps saturating link counters.
module cell_comm_rx_parser #(
   parameter int unsigned ADC_COUNT      = 4,
   parameter int unsigned FOFB_IDX_WIDTH = 9,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter logic [7:0]  MAGIC          = 8'hA5,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic                      channelUp,
   input  logic                      axisRxTvalid,
   input  logic                      axisRxTlast,
   input  logic [DATA_WIDTH-1:0]     axisRxTdata,
   input  logic                      axisRxCRCvalid,
   input  logic                      axisRxCRCpass,
   input  logic                      counterClear,
   output logic                      outValid,
   output logic [FOFB_IDX_WIDTH-1:0] outFofbIdx,
   output logic [ADC_COUNT-1:0]      outClippedAdc,
   output logic [DATA_WIDTH-1:0]     outX,
   output logic [DATA_WIDTH-1:0]     outY,
   output logic [DATA_WIDTH-1:0]     outS,
   output logic [CNT_WIDTH-1:0]      goodCount,
   output logic [CNT_WIDTH-1:0]      crcErrCount,
   output logic [CNT_WIDTH-1:0]      fmtErrCount
);

   localparam logic [2:0] S_HDR     = 3'd0;
   localparam logic [2:0] S_WX      = 3'd1;
   localparam logic [2:0] S_WY      = 3'd2;
   localparam logic [2:0] S_WS      = 3'd3;
   localparam logic [2:0] S_DISCARD = 3'd4;

   logic [2:0]                r_state;
   logic [2:0]                w_state_nxt;
   logic                      w_latch_hdr;
   logic                      w_latch_x;
   logic                      w_latch_y;
   logic                      w_emit;
   logic                      w_inc_good;
   logic                      w_inc_crc;
   logic                      w_inc_fmt;
   logic                      w_magic_ok;

   logic [FOFB_IDX_WIDTH-1:0] r_idx_hold;
   logic [ADC_COUNT-1:0]      r_flags_hold;
   logic [DATA_WIDTH-1:0]     r_x_hold;
   logic [DATA_WIDTH-1:0]     r_y_hold;

   logic                      r_out_valid;
   logic [FOFB_IDX_WIDTH-1:0] r_out_idx;
   logic [ADC_COUNT-1:0]      r_out_flags;
   logic [DATA_WIDTH-1:0]     r_out_x;
   logic [DATA_WIDTH-1:0]     r_out_y;
   logic [DATA_WIDTH-1:0]     r_out_s;
   logic [CNT_WIDTH-1:0]      r_good_cnt;
   logic [CNT_WIDTH-1:0]      r_crc_cnt;
   logic [CNT_WIDTH-1:0]      r_fmt_cnt;

   assign w_magic_ok = (axisRxTdata[31:24] == MAGIC);

   // Saturating increment; clear wins over a same-cycle increment.
   function automatic logic [CNT_WIDTH-1:0] f_cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                       input logic inc, input logic clr);
      if (clr) begin
         return '0;
      end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
         return cnt + 1'b1;
      end
      return cnt;
   endfunction

   // Next-state and per-beat action decode; each cycle yields at most one counter event.
   always_comb begin
      w_state_nxt = r_state;
      w_latch_hdr = 1'b0;
      w_latch_x   = 1'b0;
      w_latch_y   = 1'b0;
      w_emit      = 1'b0;
      w_inc_good  = 1'b0;
      w_inc_crc   = 1'b0;
      w_inc_fmt   = 1'b0;
      if (!channelUp) begin
         // Link loss mid-packet counts once: the FSM leaves WX/WY/WS on the first low cycle.
         w_state_nxt = S_HDR;
         if ((r_state == S_WX) || (r_state == S_WY) || (r_state == S_WS)) begin
            w_inc_fmt = 1'b1;
         end
      end else if (axisRxTvalid) begin
         case (r_state)
            S_HDR: begin
               if (axisRxTlast) begin
                  w_inc_fmt = 1'b1;
               end else if (!w_magic_ok) begin
                  w_inc_fmt   = 1'b1;
                  w_state_nxt = S_DISCARD;
               end else begin
                  w_latch_hdr = 1'b1;
                  w_state_nxt = S_WX;
               end
            end
            S_WX: begin
               if (axisRxTlast) begin
                  w_inc_fmt   = 1'b1;
                  w_state_nxt = S_HDR;
               end else begin
                  w_latch_x   = 1'b1;
                  w_state_nxt = S_WY;
               end
            end
            S_WY: begin
               if (axisRxTlast) begin
                  w_inc_fmt   = 1'b1;
                  w_state_nxt = S_HDR;
               end else begin
                  w_latch_y   = 1'b1;
                  w_state_nxt = S_WS;
               end
            end
            S_WS: begin
               if (!axisRxTlast) begin
                  w_inc_fmt   = 1'b1;
                  w_state_nxt = S_DISCARD;
               end else begin
                  w_state_nxt = S_HDR;
                  if (axisRxCRCvalid && axisRxCRCpass) begin
                     w_emit     = 1'b1;
                     w_inc_good = 1'b1;
                  end else begin
                     w_inc_crc = 1'b1;
                  end
               end
            end
            S_DISCARD: begin
               if (axisRxTlast) begin
                  w_state_nxt = S_HDR;
               end
            end
            default: w_state_nxt = S_HDR;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state <= S_HDR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Holding registers for header fields and X/Y until the S word arrives.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_idx_hold   <= '0;
         r_flags_hold <= '0;
         r_x_hold     <= '0;
         r_y_hold     <= '0;
      end else begin
         if (w_latch_hdr) begin
            r_idx_hold   <= axisRxTdata[0 +: FOFB_IDX_WIDTH];
            r_flags_hold <= axisRxTdata[16 +: ADC_COUNT];
         end
         if (w_latch_x) begin
            r_x_hold <= axisRxTdata;
         end
         if (w_latch_y) begin
            r_y_hold <= axisRxTdata;
         end
      end
   end

   // Output record: only a good packet updates it; S is taken straight from the tlast beat.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_out_flags <= '0;
         r_out_x     <= '0;
         r_out_y     <= '0;
         r_out_s     <= '0;
      end else begin
         r_out_valid <= w_emit;
         if (w_emit) begin
            r_out_idx   <= r_idx_hold;
            r_out_flags <= r_flags_hold;
            r_out_x     <= r_x_hold;
            r_out_y     <= r_y_hold;
            r_out_s     <= axisRxTdata;
         end
      end
   end

   // Link statistics counters.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_good_cnt <= '0;
         r_crc_cnt  <= '0;
         r_fmt_cnt  <= '0;
      end else begin
         r_good_cnt <= f_cnt_next(r_good_cnt, w_inc_good, counterClear);
         r_crc_cnt  <= f_cnt_next(r_crc_cnt, w_inc_crc, counterClear);
         r_fmt_cnt  <= f_cnt_next(r_fmt_cnt, w_inc_fmt, counterClear);
      end
   end

   assign outValid      = r_out_valid;
   assign outFofbIdx    = r_out_idx;
   assign outClippedAdc = r_out_flags;
   assign outX          = r_out_x;
   assign outY          = r_out_y;
   assign outS          = r_out_s;
   assign goodCount     = r_good_cnt;
   assign crcErrCount   = r_crc_cnt;
   assign fmtErrCount   = r_fmt_cnt;

endmodule

// File: tb/tb_cell_comm_rx_parser.sv
// Scoreboard bench for cell_comm_rx_parser: packet-level reference model pushes expected
// records, a monitor pops them on every outValid pulse.
module tb_cell_comm_rx_parser;

   localparam int unsigned CW   = 4;
   localparam int          CMAX = (1 << CW) - 1;

   typedef logic [31:0] wa_t [8];
   typedef struct {
      logic [8:0]  idx;
      logic [3:0]  flg;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] s;
      int          cyc;
   } rec_t;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic          channelUp;
   logic          axisRxTvalid;
   logic          axisRxTlast;
   logic [31:0]   axisRxTdata;
   logic          axisRxCRCvalid;
   logic          axisRxCRCpass;
   logic          counterClear;
   logic          outValid;
   logic [8:0]    outFofbIdx;
   logic [3:0]    outClippedAdc;
   logic [31:0]   outX;
   logic [31:0]   outY;
   logic [31:0]   outS;
   logic [CW-1:0] goodCount;
   logic [CW-1:0] crcErrCount;
   logic [CW-1:0] fmtErrCount;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   m_good, m_crc, m_fmt;
   rec_t last_good;
   rec_t exp_q[$];
   bit   gaps;

   cell_comm_rx_parser #(
      .ADC_COUNT     (4),
      .FOFB_IDX_WIDTH(9),
      .DATA_WIDTH    (32),
      .MAGIC         (8'hA5),
      .CNT_WIDTH     (CW)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .channelUp     (channelUp),
      .axisRxTvalid  (axisRxTvalid),
      .axisRxTlast   (axisRxTlast),
      .axisRxTdata   (axisRxTdata),
      .axisRxCRCvalid(axisRxCRCvalid),
      .axisRxCRCpass (axisRxCRCpass),
      .counterClear  (counterClear),
      .outValid      (outValid),
      .outFofbIdx    (outFofbIdx),
      .outClippedAdc (outClippedAdc),
      .outX          (outX),
      .outY          (outY),
      .outS          (outS),
      .goodCount     (goodCount),
      .crcErrCount   (crcErrCount),
      .fmtErrCount   (fmtErrCount)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // Monitor: every pulse must match the oldest expected record, including its cycle.
   initial begin
      rec_t e;
      forever begin
         @(negedge ACLK);
         if (ARESETN === 1'b1 && outValid === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_outValid actual=1 required=0 (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               chk("out_idx", 32'(outFofbIdx), 32'(e.idx));
               chk("out_flags", 32'(outClippedAdc), 32'(e.flg));
               chk("out_x", outX, e.x);
               chk("out_y", outY, e.y);
               chk("out_s", outS, e.s);
               chk("out_latency", cyc, e.cyc);
            end
         end
      end
   end

   task automatic idle();
      @(negedge ACLK);
      axisRxTvalid   = 1'b0;
      axisRxTdata    = $urandom;
      axisRxTlast    = 1'($urandom);
      axisRxCRCvalid = 1'($urandom);
      axisRxCRCpass  = 1'($urandom);
      counterClear   = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d, input logic last, input logic cv, input logic cp,
                       input logic clr);
      @(negedge ACLK);
      axisRxTvalid   = 1'b1;
      axisRxTdata    = d;
      axisRxTlast    = last;
      axisRxCRCvalid = cv;
      axisRxCRCpass  = cp;
      counterClear   = clr;
   endtask

   // Sends a chunk of len words; term=1 ends it with tlast, term=0 cuts it with a link drop.
   // Model: a tlast-terminated chunk is good/crc-error only when it is exactly 4 words with
   // the right magic, otherwise one format error; a cut chunk of >=1 word is one format error.
   task automatic send(input wa_t w, input int len, input bit term, input bit cv, input bit cp,
                       input bit clr);
      rec_t r;
      for (int i = 0; i < len; i++) begin
         if (term && i == len - 1) begin
            beat(w[i], 1'b1, cv, cp, clr);
         end else begin
            beat(w[i], 1'b0, 1'($urandom), 1'($urandom), 1'b0);
            if (gaps && $urandom_range(0, 3) == 0) idle();
         end
      end
      if (term) begin
         if (len == 4 && w[0][31:24] == 8'hA5) begin
            if (cv && cp) begin
               m_good = sat(m_good);
               r.idx = w[0][8:0];
               r.flg = w[0][19:16];
               r.x   = w[1];
               r.y   = w[2];
               r.s   = w[3];
               r.cyc = cyc + 1;
               exp_q.push_back(r);
               last_good = r;
            end else begin
               m_crc = sat(m_crc);
            end
         end else begin
            m_fmt = sat(m_fmt);
         end
         if (clr) begin
            m_good = 0;
            m_crc  = 0;
            m_fmt  = 0;
         end
      end else begin
         @(negedge ACLK);
         channelUp = 1'b0;
         repeat (4) begin
            axisRxTvalid = 1'($urandom);
            axisRxTlast  = 1'($urandom);
            axisRxTdata  = $urandom;
            @(negedge ACLK);
         end
         channelUp    = 1'b1;
         axisRxTvalid = 1'b0;
         if (len >= 1) m_fmt = sat(m_fmt);
      end
   endtask

   task automatic rand_words(output wa_t w, input bit magic_ok);
      for (int i = 0; i < 8; i++) w[i] = $urandom;
      if (magic_ok) w[0][31:24] = 8'hA5;
      else if (w[0][31:24] == 8'hA5) w[0][31:24] = 8'h5A;
   endtask

   task automatic check_state(input string tag);
      idle();
      idle();
      chk({tag, "_good"}, 32'(goodCount), 32'(m_good));
      chk({tag, "_crc"}, 32'(crcErrCount), 32'(m_crc));
      chk({tag, "_fmt"}, 32'(fmtErrCount), 32'(m_fmt));
      chk({tag, "_hold_idx"}, 32'(outFofbIdx), 32'(last_good.idx));
      chk({tag, "_hold_flags"}, 32'(outClippedAdc), 32'(last_good.flg));
      chk({tag, "_hold_x"}, outX, last_good.x);
      chk({tag, "_hold_y"}, outY, last_good.y);
      chk({tag, "_hold_s"}, outS, last_good.s);
      chk({tag, "_pending"}, exp_q.size(), 0);
   endtask

   task automatic model_reset();
      m_good = 0;
      m_crc  = 0;
      m_fmt  = 0;
      last_good = '{idx: '0, flg: '0, x: '0, y: '0, s: '0, cyc: 0};
      exp_q.delete();
   endtask

   initial begin
      wa_t w;
      ARESETN        = 1'b0;
      channelUp      = 1'b0;
      axisRxTvalid   = 1'b0;
      axisRxTlast    = 1'b0;
      axisRxTdata    = '0;
      axisRxCRCvalid = 1'b0;
      axisRxCRCpass  = 1'b0;
      counterClear   = 1'b0;
      gaps           = 1'b0;
      model_reset();
      #12;
      chk("reset_valid", 32'(outValid), 0);
      check_state("reset");
      ARESETN   = 1'b1;
      channelUp = 1'b1;
      idle();

      // Directed good packet.
      w = '{32'hA5030123, 32'h00001000, 32'hFFFFF000, 32'h00020000, 0, 0, 0, 0};
      send(w, 4, 1, 1, 1, 0);
      check_state("good1");
      chk("good1_idx_const", 32'(outFofbIdx), 32'h123);
      chk("good1_flags_const", 32'(outClippedAdc), 32'h3);

      // Back-to-back: three good, then a CRC failure.
      repeat (3) begin
         rand_words(w, 1);
         send(w, 4, 1, 1, 1, 0);
      end
      rand_words(w, 1);
      send(w, 4, 1, 1, 0, 0);
      check_state("b2b");

      // Framing errors, missing CRCvalid, then a good packet.
      w = '{32'h5A000001, 32'h1, 32'h2, 32'h3, 0, 0, 0, 0};
      send(w, 4, 1, 1, 1, 0);
      rand_words(w, 1);
      send(w, 2, 1, 1, 1, 0);
      send(w, 5, 1, 1, 1, 0);
      send(w, 1, 1, 1, 1, 0);
      send(w, 4, 1, 0, 1, 0);
      rand_words(w, 1);
      send(w, 4, 1, 1, 1, 0);
      check_state("framing");

      // Abort after X, then a good packet on reconnection.
      rand_words(w, 1);
      send(w, 2, 0, 0, 0, 0);
      rand_words(w, 1);
      send(w, 4, 1, 1, 1, 0);
      check_state("abort");

      // Saturation, then clear coinciding with a good packet's increment.
      repeat (CMAX + 2) begin
         rand_words(w, 1);
         send(w, 4, 1, 1, 1, 0);
      end
      check_state("sat");
      rand_words(w, 1);
      send(w, 4, 1, 1, 1, 1);
      check_state("clear");

      // Asynchronous reset while in WY.
      rand_words(w, 1);
      beat(w[0], 1'b0, 1'b0, 1'b0, 1'b0);
      beat(w[1], 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge ACLK);
      axisRxTvalid = 1'b0;
      #2 ARESETN = 1'b0;
      #1;
      model_reset();
      chk("arst_valid", 32'(outValid), 0);
      chk("arst_idx", 32'(outFofbIdx), 0);
      chk("arst_x", outX, 0);
      chk("arst_good", 32'(goodCount), 0);
      chk("arst_fmt", 32'(fmtErrCount), 0);
      #1 ARESETN = 1'b1;
      rand_words(w, 1);
      send(w, 4, 1, 1, 1, 0);
      check_state("arst_after");

      // Randomized traffic with gaps, aborts and occasional clears.
      gaps = 1'b1;
      for (int n = 0; n < 200; n++) begin
         int len;
         len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 4;
         rand_words(w, $urandom_range(0, 6) != 0);
         send(w, len, $urandom_range(0, 9) != 0, $urandom_range(0, 5) != 0,
              $urandom_range(0, 5) != 0, $urandom_range(0, 19) == 0);
         if (n % 20 == 19) check_state("rand");
      end
      check_state("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
